audio_dac_serializer: RTL and testbench

AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

---
 rtl/audio_dac_serializer_pkg.sv | 14 +
 rtl/audio_dac_serializer_fifo.sv | 63 ++++++
 rtl/audio_dac_serializer.sv | 121 ++++++++++++
 tb/tb_audio_dac_serializer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_dac_serializer_pkg.sv
// Shared definitions for the audio DAC serializer: default sample width,
// FIFO depth and the serializer state encoding.
package audio_dac_serializer_pkg;

   localparam int unsigned AUDIO_DATA_W = 24;
   localparam int unsigned AUDIO_DEPTH  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } ser_state_e;

endpackage

// File: rtl/audio_dac_serializer_fifo.sv
// Stereo-frame FIFO: one entry holds {left, right}. Full is taken from the
// registered level, so a same-cycle pop never frees space for a push.
module stereo_sample_fifo
   import audio_dac_serializer_pkg::*;
#(
   parameter int unsigned DATA_W = AUDIO_DATA_W,
   parameter int unsigned DEPTH  = AUDIO_DEPTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [2*DATA_W-1:0]       push_data,
   input  logic                      pop,
   output logic [2*DATA_W-1:0]       pop_data,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      full,
   output logic                      empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [2*DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]       wptr_q, wptr_d;
   logic [AW-1:0]       rptr_q, rptr_d;
   logic [LW-1:0]       level_q, level_d;
   logic                do_push, do_pop;

   assign full     = (level_q == LW'(DEPTH));
   assign empty    = (level_q == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem_q[rptr_q];
   assign level    = level_q;

   // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      if (do_push && !do_pop)      level_d = level_q + LW'(1);
      else if (!do_push && do_pop) level_d = level_q - LW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= push_data;
   end

endmodule

// File: rtl/audio_dac_serializer.sv
// Left-justified, MSB-first stereo serializer for a codec DAC. Codec clocks
// are synchronized into CLOCK_50; samples are buffered in a small frame FIFO.
module audio_dac_serializer
   import audio_dac_serializer_pkg::*;
#(
   parameter int unsigned DATA_W = AUDIO_DATA_W,
   parameter int unsigned DEPTH  = AUDIO_DEPTH
) (
   input  logic                   CLOCK_50,
   input  logic                   reset,
   input  logic                   write,
   output logic                   write_ready,
   input  logic [DATA_W-1:0]      writedata_left,
   input  logic [DATA_W-1:0]      writedata_right,
   input  logic                   AUD_BCLK,
   input  logic                   AUD_DACLRCK,
   output logic                   AUD_DACDAT,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   underflow
);

   localparam int unsigned   CW   = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] BITS = CW'(DATA_W);

   logic [2:0]          bclk_sync_q, lrck_sync_q;
   logic [2:0]          prime_q;
   logic                bclk_fall, lrck_rise, lrck_fall;
   ser_state_e          state_q, state_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [DATA_W-1:0]   hold_q, hold_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                uflow_q, uflow_d;
   logic                fifo_pop, fifo_full, fifo_empty;
   logic [2*DATA_W-1:0] fifo_data;

   stereo_sample_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (CLOCK_50),
      .rst       (reset),
      .push      (write),
      .push_data ({writedata_left, writedata_right}),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign write_ready = !fifo_full;
   assign underflow   = uflow_q;

   // Stages [0],[1] synchronize, [2] is the edge-detect stage. prime_q masks
   // the false edge that a pin already high at reset release would produce.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         bclk_sync_q <= '0;
         lrck_sync_q <= '0;
         prime_q     <= '0;
      end else begin
         bclk_sync_q <= {bclk_sync_q[1:0], AUD_BCLK};
         lrck_sync_q <= {lrck_sync_q[1:0], AUD_DACLRCK};
         prime_q     <= {prime_q[1:0], 1'b1};
      end
   end

   assign bclk_fall = prime_q[2] &&  bclk_sync_q[2] && !bclk_sync_q[1];
   assign lrck_rise = prime_q[2] && !lrck_sync_q[2] &&  lrck_sync_q[1];
   assign lrck_fall = prime_q[2] &&  lrck_sync_q[2] && !lrck_sync_q[1];

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      hold_d   = hold_q;
      cnt_d    = cnt_q;
      uflow_d  = uflow_q;
      fifo_pop = 1'b0;
      if (lrck_rise) begin
         state_d = ST_LEFT;
         cnt_d   = '0;
         if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data[2*DATA_W-1:DATA_W];
            hold_d   = fifo_data[DATA_W-1:0];
         end else begin
            shift_d = '0;
            hold_d  = '0;
            uflow_d = 1'b1;
         end
      end else if (lrck_fall) begin
         if (state_q == ST_LEFT) begin
            state_d = ST_RIGHT;
            shift_d = hold_q;
            cnt_d   = '0;
         end
      end else if (bclk_fall && state_q != ST_IDLE && cnt_q != BITS) begin
         shift_d = {shift_q[DATA_W-2:0], 1'b0};
         cnt_d   = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         hold_q  <= '0;
         cnt_q   <= '0;
         uflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         uflow_q <= uflow_d;
      end
   end

   assign AUD_DACDAT = (state_q != ST_IDLE) && (cnt_q != BITS) && shift_q[DATA_W-1];

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer: a frame scoreboard predicts every
// serial bit sampled on BCLK rising edges, plus FIFO level and underflow.
module tb_audio_dac_serializer;

   localparam int unsigned DW    = 24;
   localparam int unsigned DEPTH = 4;

   logic          CLOCK_50    = 1'b0;
   logic          reset       = 1'b1;
   logic          write       = 1'b0;
   logic          AUD_BCLK    = 1'b1;
   logic          AUD_DACLRCK = 1'b0;
   logic [DW-1:0] wl          = '0;
   logic [DW-1:0] wr          = '0;
   logic          write_ready;
   logic          AUD_DACDAT;
   logic          underflow;
   logic [2:0]    fifo_level;

   logic [2*DW-1:0] sb[$];
   logic            m_uf     = 1'b0;
   logic            last_bit = 1'b0;
   int unsigned     n_pass   = 0;
   int unsigned     n_chk    = 0;

   audio_dac_serializer #(
      .DATA_W (DW),
      .DEPTH  (DEPTH)
   ) dut (
      .CLOCK_50        (CLOCK_50),
      .reset           (reset),
      .write           (write),
      .write_ready     (write_ready),
      .writedata_left  (wl),
      .writedata_right (wr),
      .AUD_BCLK        (AUD_BCLK),
      .AUD_DACLRCK     (AUD_DACLRCK),
      .AUD_DACDAT      (AUD_DACDAT),
      .fifo_level      (fifo_level),
      .underflow       (underflow)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      @(negedge CLOCK_50);
      reset = 1'b1;
      write = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      reset = 1'b0;
      sb.delete();
      m_uf     = 1'b0;
      last_bit = 1'b0;
   endtask

   task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
      @(negedge CLOCK_50);
      write = 1'b1;
      wl    = l;
      wr    = r;
      if (sb.size() < int'(DEPTH)) sb.push_back({l, r});
      @(negedge CLOCK_50);
      write = 1'b0;
   endtask

   // One channel half: nb BCLK periods of 16 CLOCK_50 cycles; LRCK changes with
   // the first BCLK fall. Data is checked just before each BCLK rise.
   task automatic play_half(input logic lr, input int unsigned nb, input logic [DW-1:0] smp,
                            input bit frame_start, input bit wr_pop, input int pre);
      logic e;
      for (int unsigned j = 0; j < nb; j++) begin
         @(negedge CLOCK_50);
         AUD_BCLK = 1'b0;
         if (j == 0) AUD_DACLRCK = lr;
         for (int unsigned k = 1; k <= 7; k++) begin
            @(negedge CLOCK_50);
            if (j == 0 && frame_start && k == 2) begin
               chk("lvl_pre", 32'(fifo_level), 32'(pre));
               chk("dat_pre", 32'(AUD_DACDAT), 32'(last_bit));
               if (wr_pop) begin
                  write = 1'b1;
                  wl    = 24'h111111;
                  wr    = 24'h222222;
               end
            end
            if (j == 0 && frame_start && k == 3) begin
               if (wr_pop) begin
                  write = 1'b0;
                  if (pre < int'(DEPTH)) sb.push_back({24'h111111, 24'h222222});
               end
               chk("lvl_post", 32'(fifo_level), 32'(sb.size()));
               chk("uflow_post", 32'(underflow), 32'(m_uf));
               chk("dat_lat", 32'(AUD_DACDAT), 32'(smp[DW-1]));
            end
         end
         e = (j < DW) ? smp[DW-1-j] : 1'b0;
         chk(lr ? "dat_L" : "dat_R", 32'(AUD_DACDAT), 32'(e));
         last_bit = e;
         @(negedge CLOCK_50);
         AUD_BCLK = 1'b1;
         repeat (7) @(negedge CLOCK_50);
      end
   endtask

   task automatic play_frame(input int unsigned nb, input bit wr_pop);
      logic [2*DW-1:0] f;
      int              pre;
      pre = sb.size();
      if (pre > 0) f = sb.pop_front();
      else begin
         f    = '0;
         m_uf = 1'b1;
      end
      play_half(1'b1, nb, f[2*DW-1:DW], 1'b1, wr_pop, pre);
      play_half(1'b0, nb, f[DW-1:0], 1'b0, 1'b0, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic [2*DW-1:0] f;
      int              pre;

      do_reset();
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_ready", 32'(write_ready), 32'd1);
      chk("rst_dat", 32'(AUD_DACDAT), 32'd0);
      chk("rst_uflow", 32'(underflow), 32'd0);

      push(24'hA5A5A5, 24'h5A5A5A);
      chk("lvl_one", 32'(fifo_level), 32'd1);
      play_frame(32, 1'b0);
      chk("uflow_clean", 32'(underflow), 32'd0);

      push(24'h123456, 24'h654321);
      push(24'hFEDCBA, 24'h0F0F0F);
      push(24'h800001, 24'h7FFFFE);
      push(24'hC3C3C3, 24'h3C3C3C);
      chk("lvl_full", 32'(fifo_level), 32'd4);
      chk("ready_full", 32'(write_ready), 32'd0);
      push(24'hDEAD00, 24'hBEEF00);
      chk("lvl_reject", 32'(fifo_level), 32'd4);
      play_frame(32, 1'b0);
      chk("ready_after_pop", 32'(write_ready), 32'd1);

      push(24'hABCDEF, 24'h13579B);
      chk("lvl_refill", 32'(fifo_level), 32'd4);
      play_frame(32, 1'b1);
      play_frame(32, 1'b1);
      play_frame(16, 1'b0);
      play_frame(16, 1'b0);
      play_frame(32, 1'b0);
      chk("lvl_drained", 32'(fifo_level), 32'd0);
      chk("uflow_drained", 32'(underflow), 32'd0);

      push(24'h9C9C9C, 24'h636363);
      pre = sb.size();
      f   = sb.pop_front();
      play_half(1'b1, 11, f[2*DW-1:DW], 1'b1, 1'b0, pre);
      @(negedge CLOCK_50);
      reset = 1'b1;
      @(negedge CLOCK_50);
      chk("midrst_dat", 32'(AUD_DACDAT), 32'd0);
      chk("midrst_level", 32'(fifo_level), 32'd0);
      @(negedge CLOCK_50);
      reset = 1'b0;
      sb.delete();
      m_uf     = 1'b0;
      last_bit = 1'b0;
      push(24'h2468AC, 24'hFDB975);
      play_half(1'b1, 8, '0, 1'b0, 1'b0, 0);
      play_half(1'b0, 32, '0, 1'b0, 1'b0, 0);
      chk("idle_level", 32'(fifo_level), 32'd1);
      play_frame(32, 1'b0);
      chk("resume_uflow", 32'(underflow), 32'd0);

      do_reset();
      play_frame(32, 1'b0);
      play_frame(16, 1'b0);
      chk("uflow_set", 32'(underflow), 32'd1);
      push(24'h0F1E2D, 24'h3C4B5A);
      chk("uflow_sticky_push", 32'(underflow), 32'd1);
      play_frame(32, 1'b0);
      chk("uflow_sticky", 32'(underflow), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
